fcs_check: RTL

FCS_CHECK -- requirements
Module: fcs_check

---
 rtl/eth_pkg.sv | 17 +
 rtl/crc32_dibit_step.sv | 17 +
 rtl/fcs_check.sv | 114 +++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet FCS constants and the receive-checker state type.
package eth_pkg;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam int          FCS_DIBITS    = 16;
  localparam int          CNT_W         = 13;
  localparam int          LEN_W         = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM
  } fcs_state_e;

endpackage

// File: rtl/crc32_dibit_step.sv
// One reflected CRC-32 update for a dibit; dibit[0] is shifted in first.
module crc32_dibit_step
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_out
);

  logic [31:0] crc_mid;

  always_comb begin
    crc_mid = {1'b0, crc_in[31:1]} ^ ((crc_in[0] ^ dibit[0]) ? CRC_POLY_REFL : 32'h0);
    crc_out = {1'b0, crc_mid[31:1]} ^ ((crc_mid[0] ^ dibit[1]) ? CRC_POLY_REFL : 32'h0);
  end

endmodule

// File: rtl/fcs_check.sv
// Receive-side FCS checker: strips the trailing 32-bit FCS from a dibit
// stream, checks the CRC residue and reports frame length/error at frame end.
//
// state     | meaning
// ST_IDLE   | no frame in progress
// ST_FILL   | fewer than 16 dibits accepted, delay line still filling
// ST_STREAM | 16 or more dibits accepted, oldest dibit is payload
module fcs_check
  import eth_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [1:0]       axiid,
  output logic             axiov,
  output logic [1:0]       axiod,
  output logic             done,
  output logic             kerror,
  output logic [LEN_W-1:0] len
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FCS  = CNT_W'(FCS_DIBITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FCS_DIBITS - 1);

  fcs_state_e                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            pay_dibits;
  logic [31:0]                 crc_q, crc_base, crc_nxt;
  logic [FCS_DIBITS-1:0][1:0]  dl_q;
  logic                        hold_low_q;
  logic                        start, in_frame, frame_end;
  logic                        runt, misaligned, bad_crc;
  logic [LEN_W-1:0]            len_calc;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // hold_low_q blocks a frame start until axiiv has been seen low after reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (axiiv && !hold_low_q) state_d = ST_FILL;
      ST_FILL: begin
        if (!axiiv)                  state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST)  state_d = ST_STREAM;
      end
      ST_STREAM: if (!axiiv) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign start     = (state_q == ST_IDLE) && (state_d == ST_FILL);
  assign in_frame  = (state_q != ST_IDLE) && axiiv;
  assign frame_end = (state_q != ST_IDLE) && !axiiv;
  assign crc_base  = start ? CRC_INIT : crc_q;

  crc32_dibit_step u_step (
    .crc_in  (crc_base),
    .dibit   (axiid),
    .crc_out (crc_nxt)
  );

  // The FCS length is a multiple of 4 dibits, so alignment of the payload
  // count equals alignment of the whole frame. The 11-bit quotient of a
  // 13-bit count cannot exceed 2047, so saturation falls out of the width.
  assign pay_dibits = cnt_q - CNT_FCS;
  assign runt       = cnt_q < CNT_FCS;
  assign misaligned = |pay_dibits[1:0];
  assign bad_crc    = crc_q != CRC_RESIDUE;
  assign len_calc   = runt ? '0 : pay_dibits[CNT_W-1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      crc_q      <= CRC_INIT;
      dl_q       <= '0;
      hold_low_q <= 1'b1;
      axiov      <= 1'b0;
      axiod      <= 2'b00;
      done       <= 1'b0;
      kerror     <= 1'b0;
      len        <= '0;
    end else begin
      if (!axiiv) hold_low_q <= 1'b0;
      axiov  <= 1'b0;
      axiod  <= 2'b00;
      done   <= 1'b0;
      kerror <= 1'b0;
      len    <= '0;
      if (start) begin
        crc_q <= crc_nxt;
        cnt_q <= CNT_W'(1);
        dl_q  <= {{(FCS_DIBITS-1){2'b00}}, axiid};
      end else if (in_frame) begin
        crc_q <= crc_nxt;
        cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        dl_q  <= {dl_q[FCS_DIBITS-2:0], axiid};
        if (state_q == ST_STREAM) begin
          axiov <= 1'b1;
          axiod <= dl_q[FCS_DIBITS-1];
        end
      end
      if (frame_end) begin
        done   <= 1'b1;
        kerror <= runt | misaligned | bad_crc;
        len    <= len_calc;
      end
    end
  end

endmodule
